tt_um_mandelbrot_accel: RTL and testbench

- Single-point Mandelbrot escape-time engine, wrapped in the standard TinyTapeout user-project harness.
- Host loads a complex constant c and an iteration limit byte-wise, then pulses start.
- The core iterates z <= z^2 + c, one iteration per clock, and reports the iteration count and escape status on uo_out.

---
 rtl/mandelbrot_pkg.sv | 25 ++
 rtl/mandelbrot_step.sv | 51 +++++
 rtl/tt_um_mandelbrot_accel.sv | 142 ++++++++++++++
 tb/tb_tt_um_mandelbrot_accel.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg
// Shared constants and types for the Mandelbrot escape-time engine.
// Fixed-point format is Q4.12 for z and c; squared terms are Q8.24.
package mandelbrot_pkg;

    localparam int WIDTH  = 16;
    localparam int FRAC   = 12;
    localparam int ITER_W = 8;

    // 4.0 expressed in Q8.24, held in the 33-bit width of the escape sum
    localparam logic signed [2*WIDTH:0] ESCAPE_LIMIT = 33'sd67108864;

    localparam logic [2:0] ADDR_CR_LO    = 3'd0;
    localparam logic [2:0] ADDR_CR_HI    = 3'd1;
    localparam logic [2:0] ADDR_CI_LO    = 3'd2;
    localparam logic [2:0] ADDR_CI_HI    = 3'd3;
    localparam logic [2:0] ADDR_MAX_ITER = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandelbrot_step.sv
// mandelbrot_step
// One combinational Mandelbrot iteration: z' = z^2 + c, plus the escape test
// |z|^2 > 4.0 evaluated on the current z.
// Ports:
//   zr, zi   current z (Q4.12 signed)
//   cr, ci   constant c (Q4.12 signed)
//   zr_next  real part of z^2 + c, wrapped to WIDTH bits
//   zi_next  imaginary part of z^2 + c, wrapped to WIDTH bits
//   escape   1 when zr^2 + zi^2 is strictly greater than 4.0
import mandelbrot_pkg::*;

module mandelbrot_step (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] zr_next,
    output logic signed [WIDTH-1:0] zi_next,
    output logic                    escape
);

    logic signed [2*WIDTH-1:0] zr_w;
    logic signed [2*WIDTH-1:0] zi_w;
    logic signed [2*WIDTH-1:0] zr_sq;
    logic signed [2*WIDTH-1:0] zi_sq;
    logic signed [2*WIDTH-1:0] zr_zi;
    logic signed [2*WIDTH:0]   mag;
    logic signed [2*WIDTH:0]   diff;
    logic                      unused_bits;

    assign zr_w  = 32'(zr);
    assign zi_w  = 32'(zi);
    assign zr_sq = zr_w * zr_w;
    assign zi_sq = zi_w * zi_w;
    assign zr_zi = zr_w * zi_w;

    // One extra bit so neither the sum nor the difference of squares overflows
    assign mag  = 33'(zr_sq) + 33'(zi_sq);
    assign diff = 33'(zr_sq) - 33'(zi_sq);

    assign escape = (mag > ESCAPE_LIMIT);

    // Back to Q4.12 by dropping FRAC bits; the doubling of zr*zi folds into
    // taking the slice one bit lower, which also avoids a 2^31 overflow
    assign zr_next = diff[FRAC+WIDTH-1:FRAC] + cr;
    assign zi_next = zr_zi[FRAC+WIDTH-2:FRAC-1] + ci;

    assign unused_bits = ^{diff[2*WIDTH:FRAC+WIDTH], diff[FRAC-1:0],
                           zr_zi[2*WIDTH-1:FRAC+WIDTH-1], zr_zi[FRAC-2:0]};

endmodule

// File: rtl/tt_um_mandelbrot_accel.sv
// tt_um_mandelbrot_accel
// TinyTapeout wrapper around a single-point Mandelbrot escape-time engine.
// The host writes c and max_iter byte-wise, pulses start, then reads back the
// iteration count or the status flags on uo_out.
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    synchronous reset, active HIGH despite the harness name
//   ena      design selected; commands are ignored while low
//   ui_in    [2:0] address, [3] write strobe, [4] start, [5] output select
//   uio_in   write data byte
//   uo_out   sel=0: iteration count, sel=1: {busy, done, escaped, 5'b0}
//   uio_out  constant 0
//   uio_oe   constant 0, all uio pins are inputs
import mandelbrot_pkg::*;

module tt_um_mandelbrot_accel (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_t                   state;
    state_t                   state_next;
    logic signed [WIDTH-1:0]  cr;
    logic signed [WIDTH-1:0]  ci;
    logic signed [WIDTH-1:0]  zr;
    logic signed [WIDTH-1:0]  zi;
    logic signed [WIDTH-1:0]  zr_next;
    logic signed [WIDTH-1:0]  zi_next;
    logic [ITER_W-1:0]        max_iter;
    logic [ITER_W-1:0]        iter;
    logic                     escaped;
    logic                     escape;
    logic                     wr_prev;
    logic                     start_prev;
    logic                     wr_edge;
    logic                     start_edge;
    logic                     do_write;
    logic                     do_start;
    logic                     do_step;
    logic                     set_escaped;
    logic                     unused_inputs;

    mandelbrot_step u_step (
        .zr      (zr),
        .zi      (zi),
        .cr      (cr),
        .ci      (ci),
        .zr_next (zr_next),
        .zi_next (zi_next),
        .escape  (escape)
    );

    assign wr_edge    = ui_in[3] & ~wr_prev;
    assign start_edge = ui_in[4] & ~start_prev;

    // Next-state logic: commands are only honoured outside BUSY, and each
    // BUSY cycle picks escape, limit reached, or one more iteration
    always_comb begin
        state_next  = state;
        do_write    = 1'b0;
        do_start    = 1'b0;
        do_step     = 1'b0;
        set_escaped = 1'b0;
        case (state)
            IDLE, DONE: begin
                do_write = ena & wr_edge;
                do_start = ena & start_edge;
                if (do_start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (escape) begin
                    state_next  = DONE;
                    set_escaped = 1'b1;
                end else if (iter == max_iter) begin
                    state_next = DONE;
                end else begin
                    do_step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, config registers, iteration datapath and edge history
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            cr         <= '0;
            ci         <= '0;
            max_iter   <= '1;
            zr         <= '0;
            zi         <= '0;
            iter       <= '0;
            escaped    <= 1'b0;
            wr_prev    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            state      <= state_next;
            wr_prev    <= ui_in[3];
            start_prev <= ui_in[4];
            if (do_write) begin
                case (ui_in[2:0])
                    ADDR_CR_LO:    cr[7:0]   <= uio_in;
                    ADDR_CR_HI:    cr[15:8]  <= uio_in;
                    ADDR_CI_LO:    ci[7:0]   <= uio_in;
                    ADDR_CI_HI:    ci[15:8]  <= uio_in;
                    ADDR_MAX_ITER: max_iter  <= uio_in;
                    default:       ;
                endcase
            end
            if (do_start) begin
                zr      <= '0;
                zi      <= '0;
                iter    <= '0;
                escaped <= 1'b0;
            end else if (do_step) begin
                zr   <= zr_next;
                zi   <= zi_next;
                iter <= iter + 1'b1;
            end
            if (set_escaped) begin
                escaped <= 1'b1;
            end
        end
    end

    assign uo_out  = ui_in[5] ? {(state == BUSY), (state == DONE), escaped, 5'b0}
                              : iter;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign unused_inputs = ^ui_in[7:6];

endmodule

// File: tb/tb_tt_um_mandelbrot_accel.sv
// tb_tt_um_mandelbrot_accel
// Scoreboard bench for the Mandelbrot engine: each configured run pushes its
// expected count, status and busy length, and the run task pops and compares.
`timescale 1ns/1ps

module tb_tt_um_mandelbrot_accel;

    localparam logic [2:0] A_CR_LO = 3'd0;
    localparam logic [2:0] A_CR_HI = 3'd1;
    localparam logic [2:0] A_CI_LO = 3'd2;
    localparam logic [2:0] A_CI_HI = 3'd3;
    localparam logic [2:0] A_MAX   = 3'd4;

    typedef struct {
        int count;
        int status;
        int cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [2:0] addr = 3'd0;
    logic       wr = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    assign ui_in = {2'b00, sel, start, wr, addr};

    tt_um_mandelbrot_accel dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (data),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference of the escape-time iteration
    task automatic model(input logic signed [15:0] cr, input logic signed [15:0] ci,
                         input int mx, output int cnt, output bit esc);
        logic signed [15:0] zr = 16'sd0;
        logic signed [15:0] zi = 16'sd0;
        logic signed [15:0] tr;
        logic signed [15:0] ti;
        longint a, b, p;
        cnt = 0;
        esc = 1'b0;
        for (int k = 0; k <= mx; k++) begin
            a = longint'(zr) * longint'(zr);
            b = longint'(zi) * longint'(zi);
            p = longint'(zr) * longint'(zi);
            if (a + b > 64'sd67108864) begin
                esc = 1'b1;
                break;
            end
            if (cnt == mx) break;
            tr = 16'((a - b) >>> 12);
            ti = 16'((2 * p) >>> 12);
            zr = tr + cr;
            zi = ti + ci;
            cnt++;
        end
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        data = d;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic pushExpected(input int cnt, input bit esc);
        exp_t e;
        e.count  = cnt;
        e.status = esc ? 32'h60 : 32'h40;
        e.cycles = cnt + 1;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] cr, input logic [15:0] ci,
                                 input logic [7:0] mx, input int cnt, input bit esc);
        writeReg(A_CR_LO, cr[7:0]);
        writeReg(A_CR_HI, cr[15:8]);
        writeReg(A_CI_LO, ci[7:0]);
        writeReg(A_CI_HI, ci[15:8]);
        writeReg(A_MAX, mx);
        pushExpected(cnt, esc);
    endtask

    task automatic applyModel(input logic [15:0] cr, input logic [15:0] ci, input logic [7:0] mx);
        int cnt;
        bit esc;
        model(cr, ci, int'(mx), cnt, esc);
        applyStimulus(cr, ci, mx, cnt, esc);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // action 1: start re-pulsed mid-run; action 2: write cr_hi=0x20 mid-run
    task automatic runAndCheck(input int action);
        exp_t e;
        int   busy_cycles = 0;
        bit   finished = 1'b0;
        sel = 1'b1;
        pulseStart();
        for (int n = 0; n < 400; n++) begin
            #1;
            if (!uo_out[7]) begin
                finished = 1'b1;
                break;
            end
            busy_cycles++;
            if (busy_cycles == 3 && action == 1) start = 1'b1;
            if (busy_cycles == 3 && action == 2) begin
                addr = A_CR_HI;
                data = 8'h20;
                wr   = 1'b1;
            end
            if (busy_cycles == 4) begin
                start = 1'b0;
                wr    = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr    = 1'b0;
        if (!finished) checkOutput("timeout", 0, 1);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            checkOutput("busy_cycles", busy_cycles, e.cycles);
            checkOutput("status", {24'h0, uo_out}, e.status);
            sel = 1'b0;
            #1;
            checkOutput("count", {24'h0, uo_out}, e.count);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        #1 checkOutput("reset_status", {24'h0, uo_out}, 32'h00);
        sel = 1'b0;
        #1 checkOutput("reset_count", {24'h0, uo_out}, 32'h00);
        checkOutput("uio_oe", {24'h0, uio_oe}, 32'h00);
        checkOutput("uio_out", {24'h0, uio_out}, 32'h00);

        applyStimulus(16'h0000, 16'h0000, 8'd10, 10, 1'b0);
        runAndCheck(0);
        applyStimulus(16'h2000, 16'h0000, 8'd10, 2, 1'b1);
        runAndCheck(0);
        applyStimulus(16'h1000, 16'h1000, 8'd10, 2, 1'b1);
        runAndCheck(0);
        applyStimulus(16'hE000, 16'h0000, 8'd50, 50, 1'b0);
        runAndCheck(0);

        // Deselected: neither the write nor the start may take effect
        ena = 1'b0;
        writeReg(A_CR_HI, 8'h20);
        sel = 1'b1;
        pulseStart();
        #1 checkOutput("ena0_status", {24'h0, uo_out}, 32'h40);
        sel = 1'b0;
        #1 checkOutput("ena0_count", {24'h0, uo_out}, 32'd50);
        ena = 1'b1;
        pushExpected(50, 1'b0);
        runAndCheck(0);

        applyStimulus(16'h0000, 16'h0000, 8'd0, 0, 1'b0);
        runAndCheck(0);

        applyModel(16'hF400, 16'h0199, 8'd60);
        runAndCheck(0);
        applyModel(16'h04CD, 16'h0800, 8'd40);
        runAndCheck(0);
        applyModel(16'h1800, 16'hF000, 8'd20);
        runAndCheck(0);

        applyStimulus(16'h0000, 16'h0000, 8'd20, 20, 1'b0);
        runAndCheck(1);
        pushExpected(20, 1'b0);
        runAndCheck(2);
        pushExpected(20, 1'b0);
        runAndCheck(0);

        // Reset in the middle of a run, then confirm reset register values
        writeReg(A_CR_HI, 8'h00);
        writeReg(A_MAX, 8'd100);
        sel = 1'b1;
        pulseStart();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 checkOutput("midrst_status", {24'h0, uo_out}, 32'h00);
        sel = 1'b0;
        #1 checkOutput("midrst_count", {24'h0, uo_out}, 32'h00);
        rst = 1'b0;
        pushExpected(255, 1'b0);
        runAndCheck(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
